// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer with start/done valid-ready handshakes
// One shared 1-bit add stage (two half-add cells + OR) processes operands LSB-first.

module half_add (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic             c;
  logic [CW-1:0]    count;
  logic             p, g, s, pc, co, last;

  half_add u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(p), .c(g));
  half_add u_ha1 (.x(p),       .y(c),       .s(s), .c(pc));
  assign co   = g | pc;
  assign last = (count == CW'(WIDTH - 1));

  // New bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB of the sum.
  generate
    if (WIDTH == 1) begin : g_acc1
      assign acc_nx = s;
    end else begin : g_accn
      assign acc_nx = {s, acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      c     <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= cin;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          acc  <= acc_nx;
          c    <= co;
          if (last) begin
            sum  <= acc_nx;
            cout <= co;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
// Vector table plus scoreboard of a+b+cin results keyed on start/done handshakes.

module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0;
  logic             done_valid;
  logic             done_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [WIDTH:0] sb_q[$];
  logic [WIDTH:0] prev_res;
  logic           prev_dv;

  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               stall;
  } vec_t;
  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin), .done_valid(done_valid), .done_ready(done_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and per-cycle invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_valid && start_ready)
        sb_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
      if (done_valid && done_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else                  chk("sb_result", {cout, sum}, sb_q.pop_front());
      end
      chk("busy_vs_ready", busy, !start_ready);
      if (!(done_valid && !prev_dv)) chk("sum_stable", {cout, sum}, prev_res);
    end
    prev_res = {cout, sum};
    prev_dv  = done_valid;
  end

  task automatic start_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic);
    int n;
    start_valid = 1'b1; a = ia; b = ib; cin = ic;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (start_ready) break;
      n++;
    end
    if (n >= 40) chk("start_timeout", 1, 0);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_valid) chk("done_timeout", 1, 0);
  endtask

  task automatic finish_op(input int stall);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("hold_valid", done_valid, 1);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc_cyc[3];
    logic [WIDTH-1:0] pa[3], pb[3];
    logic             pc[3];

    vecs[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 2};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 3};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1};

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, each with latency and result checks
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk("busy_after_accept", busy, 1);
      wait_done(lat);
      chk("latency", lat, WIDTH);
      chk("vec_sum", sum, vecs[i].sum);
      chk("vec_cout", cout, vecs[i].cout);
      finish_op(vecs[i].stall);
    end

    // Backpressure in DONE with ignored start requests
    start_op(8'h21, 8'h13, 1'b0);
    wait_done(lat);
    start_valid = 1'b1; a = 8'hAA; b = 8'h01; cin = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_done_valid", done_valid, 1);
      chk("bp_start_ready", start_ready, 0);
      chk("bp_sum", {cout, sum}, 9'h034);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("bp_idle_ready", start_ready, 1);
    chk("bp_idle_sum", sum, 8'h34);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("bp_new_accept", busy, 1);
    wait_done(lat);
    chk("bp_new_sum", {cout, sum}, 9'h0AB);
    finish_op(0);

    // Mid-operation reset
    start_op(8'h0F, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_done_valid", done_valid, 0);
    chk("mid_rst_busy", busy, 0);
    sb_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", start_ready, 1);
    start_op(8'h10, 8'h20, 1'b0);
    wait_done(lat);
    chk("post_rst_sum", {cout, sum}, 9'h030);
    finish_op(0);

    // Back-to-back with both handshakes tied high
    pa = '{8'h11, 8'hF0, 8'h9C};
    pb = '{8'h22, 8'h20, 8'h64};
    pc = '{1'b1, 1'b0, 1'b1};
    done_ready = 1'b1;
    start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      a = pa[k]; b = pb[k]; cin = pc[k];
      n = 0;
      while (n < 40) begin
        @(negedge clk);
        if (start_ready) break;
        n++;
      end
      if (n >= 40) chk("b2b_timeout", 1, 0);
      acc_cyc[k] = cyc;
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    chk("b2b_interval0", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
    chk("b2b_interval1", acc_cyc[2] - acc_cyc[1], WIDTH + 2);
    for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("b2b_drained", sb_q.size(), 0);
    @(posedge clk); #1;
    done_ready = 1'b0;

    // Random sweep with random stalls and gaps
    for (int i = 0; i < 200; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      wait_done(lat);
      chk("rand_latency", lat, WIDTH);
      finish_op($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
